// File: rtl/waterfall_pkg.sv
// Shared framebuffer geometry, pixel format and writer state encoding.
// The pixel is the top PIX_W bits of the 12-bit ADC sample.
package waterfall_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_ADDR_W = 17;
  localparam int PIX_W     = 8;
  localparam int SAMPLE_W  = 12;
  localparam int TOP_W     = 8;

  typedef enum logic [1:0] {
    ST_CAPTURE    = 2'd0,
    ST_WAIT_BLANK = 2'd1,
    ST_WRITE      = 2'd2
  } wf_state_t;

  // Shift keeps every sample bit in the expression; only the top byte survives the cast.
  function automatic logic [PIX_W-1:0] sample_to_pix(input logic [SAMPLE_W-1:0] s);
    return PIX_W'(s >> (SAMPLE_W - PIX_W));
  endfunction

endpackage

// File: rtl/waterfall_writer_if.sv
// ADC sample input, vblank status and framebuffer write port of the waterfall writer.
// slave is the writer side; master is whoever feeds samples and owns the RAM.
interface waterfall_writer_if
  import waterfall_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W
) ();

  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_data;
  logic                vblank;
  logic [ADDR_W-1:0]   ram_addr;
  logic [PIX_W-1:0]    ram_wdata;
  logic                ram_we;
  logic [TOP_W-1:0]    top_line;
  logic                line_done;
  logic                overrun;

  modport master (
    output sample_valid, sample_data, vblank,
    input  ram_addr, ram_wdata, ram_we, top_line, line_done, overrun
  );

  modport slave (
    input  sample_valid, sample_data, vblank,
    output ram_addr, ram_wdata, ram_we, top_line, line_done, overrun
  );

endinterface

// File: rtl/waterfall_line_buf.sv
// One-line pixel store: single write port, synchronous read port with one cycle of latency.
// Read register has a synchronous clear so the framebuffer data output comes out of reset at zero.
module waterfall_line_buf #(
  parameter int DEPTH = 320,
  parameter int DAT_W = 8,
  parameter int AW    = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [DAT_W-1:0] i_wr_dat,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [DAT_W-1:0] o_rd_dat
);

  logic [DAT_W-1:0] r_mem [DEPTH];
  logic [DAT_W-1:0] r_rd_dat;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_dat <= '0;
    end else if (i_rd_en) begin
      r_rd_dat <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/waterfall_writer.sv
// Captures one decimated ADC line, then copies it into the next circular framebuffer row during vblank.
// Writes land one cycle after the column is issued; the copy pauses while vblank is low; off-capture samples are dropped.
module waterfall_writer
  import waterfall_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int DECIM  = 1,
  parameter int ADDR_W = FB_ADDR_W
) (
  input logic               clk,
  input logic               reset,
  waterfall_writer_if.slave bus
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int DEC_W = (DECIM  > 1) ? $clog2(DECIM)  : 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [DEC_W-1:0]  DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

  wf_state_t          r_state;
  wf_state_t          w_state_nxt;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_wr_row;
  logic [ADDR_W-1:0]  r_row_base;
  logic [DEC_W-1:0]   r_decim_cnt;
  logic               r_vblank_d;
  logic [ADDR_W-1:0]  r_ram_addr;
  logic               r_ram_we;
  logic               r_line_done;
  logic               r_overrun;

  logic               w_kept;
  logic               w_col_last;
  logic               w_vblank_rise;
  logic               w_store;
  logic               w_issue;
  logic [PIX_W-1:0]   w_pix;
  logic [PIX_W-1:0]   w_rd_dat;

  assign w_kept        = bus.sample_valid && (r_decim_cnt == '0);
  assign w_col_last    = (r_col == COL_LAST);
  assign w_vblank_rise = bus.vblank && !r_vblank_d;
  assign w_pix         = sample_to_pix(bus.sample_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CAPTURE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_issue     = 1'b0;
    unique case (r_state)
      ST_CAPTURE: begin
        w_store = w_kept;
        if (w_kept && w_col_last) begin
          w_state_nxt = ST_WAIT_BLANK;
        end
      end
      // Only a fresh rising edge starts the copy, so it always gets a whole blank interval.
      ST_WAIT_BLANK: begin
        if (w_vblank_rise) begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_issue = bus.vblank;
        if (bus.vblank && w_col_last) begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      default: begin
        w_state_nxt = ST_CAPTURE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col       <= '0;
      r_wr_row    <= '0;
      r_row_base  <= '0;
      r_decim_cnt <= '0;
      r_vblank_d  <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_line_done <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_vblank_d  <= bus.vblank;
      r_ram_we    <= w_issue;
      r_line_done <= w_issue && w_col_last;
      r_overrun   <= w_kept && (r_state != ST_CAPTURE);

      // The decimation phase keeps running even while samples are being dropped.
      if (bus.sample_valid) begin
        r_decim_cnt <= (r_decim_cnt == DEC_LAST) ? '0 : r_decim_cnt + 1'b1;
      end

      if (w_store || w_issue) begin
        r_col <= w_col_last ? '0 : r_col + 1'b1;
      end

      if (w_issue) begin
        r_ram_addr <= r_row_base + ADDR_W'(r_col);
      end

      if (w_issue && w_col_last) begin
        if (r_wr_row == ROW_LAST) begin
          r_wr_row   <= '0;
          r_row_base <= '0;
        end else begin
          r_wr_row   <= r_wr_row + 1'b1;
          r_row_base <= r_row_base + ROW_STEP;
        end
      end
    end
  end

  waterfall_line_buf #(
    .DEPTH (WIDTH),
    .DAT_W (PIX_W),
    .AW    (COL_W)
  ) u_line_buf (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_wr_en   (w_store),
    .i_wr_addr (r_col),
    .i_wr_dat  (w_pix),
    .i_rd_en   (w_issue),
    .i_rd_addr (r_col),
    .o_rd_dat  (w_rd_dat)
  );

  // The row just finished becomes the newest, so the oldest row is the one written next.
  assign bus.top_line  = TOP_W'(r_wr_row);
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = w_rd_dat;
  assign bus.ram_we    = r_ram_we;
  assign bus.line_done = r_line_done;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_waterfall_writer.sv
// Scoreboard bench: stimulus queues the expected framebuffer writes, a negedge monitor pops and compares.
// dut0 uses full geometry with DECIM=1; dut1 uses a 3-row framebuffer with DECIM=4 to reach the row wrap quickly.
module tb_waterfall_writer;
  import waterfall_pkg::*;

  localparam int W  = FB_WIDTH;
  localparam int H0 = FB_HEIGHT;
  localparam int H1 = 3;

  typedef struct {
    int addr;
    int data;
    int last;
    int top;
  } wr_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        sv [2];
  logic [11:0] sd [2];
  logic        vb [2];

  int n_total = 0;
  int n_bad   = 0;
  int n_wr     [2];
  int done_cnt [2];
  int ov_cnt   [2];
  int cur_row  [2];
  int pix      [2][W];
  int top_tbl  [3] = '{2, 0, 1};
  wr_t exp_q0 [$];
  wr_t exp_q1 [$];

  always #5 clk = ~clk;

  waterfall_writer_if #(.ADDR_W(FB_ADDR_W)) bus0 ();
  waterfall_writer_if #(.ADDR_W(FB_ADDR_W)) bus1 ();

  assign bus0.sample_valid = sv[0];
  assign bus0.sample_data  = sd[0];
  assign bus0.vblank       = vb[0];
  assign bus1.sample_valid = sv[1];
  assign bus1.sample_data  = sd[1];
  assign bus1.vblank       = vb[1];

  waterfall_writer #(.WIDTH(W), .HEIGHT(H0), .DECIM(1), .ADDR_W(FB_ADDR_W)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  waterfall_writer #(.WIDTH(W), .HEIGHT(H1), .DECIM(4), .ADDR_W(FB_ADDR_W)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic mon(input int s, input logic we, input logic [FB_ADDR_W-1:0] addr,
                     input logic [7:0] wd, input logic ld, input logic ov, input logic [7:0] tl);
    wr_t e;
    if (ov === 1'b1) ov_cnt[s]++;
    if (ld === 1'b1) done_cnt[s]++;
    if (we === 1'b1) begin
      n_wr[s]++;
      if (qsize(s) == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_write dut%0d: got write at addr %0d expected none", s, addr);
      end else begin
        if (s == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        chk("wr_addr", 32'(addr), e.addr);
        chk("wr_data", 32'(wd), e.data);
        chk("line_done_on_write", 32'(ld), e.last);
        if (e.last != 0) chk("top_line_at_done", 32'(tl), e.top);
      end
    end else if (ld === 1'b1) begin
      n_total++;
      n_bad++;
      $display("FAIL line_done_no_write dut%0d: got line_done=1 expected 0 without write", s);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0, bus0.ram_we, bus0.ram_addr, bus0.ram_wdata, bus0.line_done, bus0.overrun, bus0.top_line);
      mon(1, bus1.ram_we, bus1.ram_addr, bus1.ram_wdata, bus1.line_done, bus1.overrun, bus1.top_line);
    end
  end

  // One strobe per cycle; with decimation d, strobe j lands in column j/d when j%d==0.
  task automatic capture(input int s, input int start);
    int dec = (s == 0) ? 1 : 4;
    for (int j = 0; j < W * dec; j++) begin
      sv[s] = 1'b1;
      sd[s] = 12'((start + j) << 4);
      if (j % dec == 0) pix[s][j / dec] = (start + j) & 8'hFF;
      tick();
    end
    sv[s] = 1'b0;
  endtask

  task automatic expect_line(input int s);
    int  h   = (s == 0) ? H0 : H1;
    int  row = cur_row[s];
    wr_t e;
    for (int c = 0; c < W; c++) begin
      e.addr = row * W + c;
      e.data = pix[s][c];
      e.last = (c == W - 1) ? 1 : 0;
      e.top  = (row + 1) % h;
      if (s == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
    cur_row[s] = (row + 1) % h;
  endtask

  task automatic wait_done(input int s, input int prev);
    int t = 0;
    while (done_cnt[s] == prev && t < 2000) begin
      tick();
      t++;
    end
    chk("line_done_count", done_cnt[s] - prev, 1);
    chk("queue_drained", qsize(s), 0);
  endtask

  task automatic copy(input int s);
    int prev = done_cnt[s];
    expect_line(s);
    vb[s] = 1'b0;
    tick();
    vb[s] = 1'b1;
    wait_done(s, prev);
    vb[s] = 1'b0;
    tick();
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int base;
    int prev;
    for (int s = 0; s < 2; s++) begin
      sv[s] = 1'b0; sd[s] = '0; vb[s] = 1'b0;
      n_wr[s] = 0; done_cnt[s] = 0; ov_cnt[s] = 0; cur_row[s] = 0;
    end

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_ram_addr", 32'(bus0.ram_addr), 0);
    chk("rst_ram_wdata", 32'(bus0.ram_wdata), 0);
    chk("rst_ram_we", 32'(bus0.ram_we), 0);
    chk("rst_top_line", 32'(bus0.top_line), 0);
    chk("rst_line_done", 32'(bus0.line_done), 0);
    chk("rst_overrun", 32'(bus0.overrun), 0);
    chk("rst_top_line_dut1", 32'(bus1.top_line), 0);
    reset = 1'b0;
    tick();

    // Single line: addr 0..319, data i&0xFF, top_line -> 1
    capture(0, 0);
    copy(0);
    chk("single_top_line", 32'(bus0.top_line), 1);
    chk("single_write_count", n_wr[0], 320);

    // Copy paused by vblank low: 99 columns, quiet gap, then the rest
    capture(0, 100);
    expect_line(0);
    prev = done_cnt[0];
    base = n_wr[0];
    vb[0] = 1'b0;
    tick();
    vb[0] = 1'b1;
    repeat (100) tick();
    vb[0] = 1'b0;
    tick();
    chk("pause_first_part", n_wr[0] - base, 99);
    base = n_wr[0];
    repeat (49) tick();
    chk("pause_quiet", n_wr[0] - base, 0);
    vb[0] = 1'b1;
    wait_done(0, prev);
    vb[0] = 1'b0;
    tick();
    chk("pause_write_count", n_wr[0], 640);
    chk("pause_top_line", 32'(bus0.top_line), 2);

    // vblank already high when capture finishes: no copy until a fresh edge
    vb[0] = 1'b1;
    tick();
    capture(0, 37);
    base = n_wr[0];
    repeat (30) tick();
    chk("high_vblank_no_write", n_wr[0] - base, 0);
    copy(0);
    chk("high_vblank_top_line", 32'(bus0.top_line), 3);

    // Reset in the middle of a copy
    capture(0, 200);
    expect_line(0);
    vb[0] = 1'b0;
    tick();
    vb[0] = 1'b1;
    repeat (50) tick();
    reset = 1'b1;
    tick();
    exp_q0.delete();
    chk("midrst_ram_we", 32'(bus0.ram_we), 0);
    chk("midrst_top_line", 32'(bus0.top_line), 0);
    repeat (2) begin
      tick();
      chk("midrst_ram_we_hold", 32'(bus0.ram_we), 0);
    end
    reset = 1'b0;
    vb[0] = 1'b0;
    cur_row[0] = 0;
    base = n_wr[0];
    capture(0, 5);
    repeat (20) tick();
    chk("post_rst_no_write", n_wr[0] - base, 0);
    copy(0);
    chk("post_rst_top_line", 32'(bus0.top_line), 1);

    // DECIM=4: every 4th sample kept; one kept strobe during WRITE flags overrun and is not stored
    capture(1, 0);
    expect_line(1);
    prev = done_cnt[1];
    vb[1] = 1'b0;
    tick();
    chk("decim_no_overrun_in_wait", ov_cnt[1], 0);
    vb[1] = 1'b1;
    tick();
    sv[1] = 1'b1;
    sd[1] = 12'hABC;
    repeat (4) tick();
    sv[1] = 1'b0;
    wait_done(1, prev);
    vb[1] = 1'b0;
    tick();
    chk("overrun_once", ov_cnt[1], 1);
    chk("dut1_top_line", 32'(bus1.top_line), 1);

    // Row wrap on the 3-row instance: bases 320, 640, then back to 0
    for (int l = 0; l < 3; l++) begin
      capture(1, 11 * (l + 1));
      copy(1);
      chk("dut1_top_line", 32'(bus1.top_line), top_tbl[l]);
    end

    chk("dut0_no_overrun", ov_cnt[0], 0);
    chk("dut0_done_total", done_cnt[0], 4);
    chk("dut1_done_total", done_cnt[1], 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
